// File: rtl/uart_tx_feeder.sv
// Byte FIFO and launch controller feeding a UART transmitter: queues host bytes,
// holds each on data_byte with tx_en high for one frame, and aborts hung frames.
module uart_tx_feeder #(
   parameter int          DEPTH   = 16,
   parameter int          ADDR_W  = 4,
   parameter logic [31:0] TIMEOUT = 32'd2000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   fifo_count,
   output logic              overflow,
   output logic              timeout_err,
   output logic              tx_en,
   output logic [7:0]        data_byte,
   input  logic              tx_done,
   input  logic              uart_state
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

   state_t            state, state_next;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [31:0]       watchdog;
   logic              pop, push, wd_expire;
   logic [ADDR_W:0]   count_next;

   // A pop is the launch of a frame; a write while full survives only if it pairs with one.
   always_comb begin
      pop        = (state == IDLE) && !empty && !uart_state && !tx_done;
      push       = wr_en && (!full || pop);
      wd_expire  = (state == SEND) && !tx_done && (watchdog == TIMEOUT - 32'd1);
      count_next = fifo_count;
      if (push && !pop)
         count_next = fifo_count + CNT_ONE;
      else if (pop && !push)
         count_next = fifo_count - CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pop) state_next = SEND;
         SEND:    if (tx_done || wd_expire) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      tx_en = (state == SEND);
   end

   // NOTE: non-blocking assignments here so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         full        <= 1'b0;
         empty       <= 1'b1;
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
         data_byte   <= 8'h00;
         watchdog    <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) begin
            rd_ptr    <= rd_ptr + PTR_ONE;
            data_byte <= mem[rd_ptr];
         end
         fifo_count <= count_next;
         full       <= (count_next == DEPTH_CNT);
         empty      <= (count_next == '0);
         if (wr_en && full && !pop)
            overflow <= 1'b1;
         if (wd_expire)
            timeout_err <= 1'b1;
         if (pop)
            watchdog <= '0;
         else if (state == SEND)
            watchdog <= watchdog + 32'd1;
      end
   end

   // NOTE: storage is deliberately left unreset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wr_data;
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: accepted writes queue expected bytes, a monitor
// pops them on each tx_en launch; a second instance with a short watchdog covers aborts.
module tb_uart_tx_feeder;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              reset, wr_en, tx_done, uart_state;
   logic [7:0]        wr_data;
   logic              full, empty, overflow, timeout_err, tx_en;
   logic [ADDR_W:0]   fifo_count;
   logic [7:0]        data_byte;

   logic              w_reset, w_wr_en, w_tx_done, w_uart_state;
   logic [7:0]        w_wr_data;
   logic              w_full, w_empty, w_overflow, w_timeout_err, w_tx_en;
   logic [ADDR_W:0]   w_fifo_count;
   logic [7:0]        w_data_byte;

   always #10 clk = ~clk;

   uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(32'd1000)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .empty(empty), .fifo_count(fifo_count), .overflow(overflow),
      .timeout_err(timeout_err), .tx_en(tx_en), .data_byte(data_byte),
      .tx_done(tx_done), .uart_state(uart_state)
   );

   uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(32'd8)) dut_wd (
      .clk(clk), .reset(w_reset), .wr_en(w_wr_en), .wr_data(w_wr_data),
      .full(w_full), .empty(w_empty), .fifo_count(w_fifo_count), .overflow(w_overflow),
      .timeout_err(w_timeout_err), .tx_en(w_tx_en), .data_byte(w_data_byte),
      .tx_done(w_tx_done), .uart_state(w_uart_state)
   );

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] exp_q[$];
   int         gaps[$];
   int         n_launch = 0;
   int         launch_base = 0;
   int         n_acc = 0;
   int         frame_len = 5;
   bit         rand_len = 1'b0;
   int         hi, n, g0, bad;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Transmitter model: pulses tx_done during the frame_len-th cycle of each frame (0 = never).
   initial begin
      int cyc = 0;
      int len = 5;
      tx_done = 1'b0;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (tx_en) begin
            cyc++;
            if (cyc == 1)
               len = rand_len ? int'($urandom_range(1, 12)) : frame_len;
            if (len != 0 && cyc == len)
               tx_done = 1'b1;
         end else begin
            cyc = 0;
         end
      end
   end

   // Monitor: every tx_en launch must present the oldest outstanding accepted byte.
   initial begin
      logic       prev = 1'b0;
      logic [7:0] held = 8'h00;
      int         gap = 0;
      bit         seen = 1'b0;
      bit         stable = 1'b1;
      forever begin
         @(negedge clk);
         if (tx_en && !prev) begin
            n_launch++;
            if (seen)
               gaps.push_back(gap);
            held   = data_byte;
            stable = 1'b1;
            check("launch_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
               check("tx_byte", data_byte, exp_q.pop_front());
         end else if (tx_en && data_byte !== held) begin
            stable = 1'b0;
         end
         if (!tx_en && prev) begin
            check("byte_stable", stable, 1);
            seen = 1'b1;
            gap  = 0;
         end
         if (!tx_en)
            gap++;
         prev = tx_en;
      end
   end

   task automatic push(input logic [7:0] b, input bit acc);
      wr_en   = 1'b1;
      wr_data = b;
      if (acc) begin
         exp_q.push_back(b);
         n_acc++;
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wr_en = 1'b0;
      exp_q.delete();
      @(negedge clk);
      reset       = 1'b0;
      n_acc       = 0;
      launch_base = n_launch;
   endtask

   task automatic drain(input string name, input int budget);
      int k = 0;
      uart_state = 1'b0;
      while ((exp_q.size() != 0 || tx_en) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, exp_q.size(), 0);
      check({name, "_idle"}, tx_en, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; uart_state = 1'b0;
      w_reset = 1'b1; w_wr_en = 1'b0; w_wr_data = 8'h00; w_tx_done = 1'b0; w_uart_state = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0; w_reset = 1'b0;

      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_count", fifo_count, 0);
      check("rst_overflow", overflow, 0);
      check("rst_timeout_err", timeout_err, 0);
      check("rst_tx_en", tx_en, 0);
      check("rst_data_byte", data_byte, 8'h00);

      // Single byte, 100-cycle frame
      frame_len = 100;
      push(8'hA5, 1'b1);
      check("sb_empty_after_write", empty, 0);
      check("sb_tx_en_cycle1", tx_en, 0);
      @(negedge clk);
      check("sb_tx_en_cycle2", tx_en, 1);
      check("sb_data_byte", data_byte, 8'hA5);
      hi = 0;
      while (tx_en === 1'b1 && hi < 300) begin
         hi++;
         @(negedge clk);
      end
      check("sb_frame_cycles", hi, 100);
      check("sb_empty_end", empty, 1);
      check("sb_count_end", fifo_count, 0);

      // Burst of 16 held by a busy transmitter, then released
      frame_len = 3;
      do_reset();
      uart_state = 1'b1;
      for (int i = 1; i <= 16; i++)
         push(8'(i), 1'b1);
      check("burst_full", full, 1);
      check("burst_count", fifo_count, 16);
      repeat (4) begin
         check("busy_hold_tx_en", tx_en, 0);
         @(negedge clk);
      end
      g0 = gaps.size();
      uart_state = 1'b0;
      @(negedge clk);
      check("busy_release_tx_en", tx_en, 1);
      drain("burst_drain", 500);
      bad = 0;
      for (int i = g0 + 1; i < gaps.size(); i++)
         if (gaps[i] != 1) bad++;
      check("burst_launches", gaps.size() - g0, 16);
      check("burst_gaps_one_cycle", bad, 0);
      check("burst_empty", empty, 1);
      check("burst_count_end", fifo_count, 0);

      // Overflow, then a write while full paired with a pop
      do_reset();
      uart_state = 1'b1;
      for (int i = 0; i < 16; i++)
         push(8'h20 + 8'(i), 1'b1);
      push(8'hFF, 1'b0);
      check("ovf_flag", overflow, 1);
      check("ovf_count", fifo_count, 16);
      check("ovf_full", full, 1);
      uart_state = 1'b0;
      push(8'h77, 1'b1);
      check("full_pop_count", fifo_count, 16);
      check("full_pop_overflow", overflow, 1);
      check("full_pop_launch", tx_en, 1);
      rand_len = 1'b1;
      drain("ovf_drain", 800);
      check("ovf_launches", n_launch - launch_base, 17);

      // Reset in the middle of a frame with bytes queued
      rand_len  = 1'b0;
      frame_len = 50;
      push(8'hC1, 1'b1);
      push(8'hC2, 1'b1);
      push(8'hC3, 1'b1);
      n = 0;
      while (!tx_en && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("mid_launch", tx_en, 1);
      repeat (5) @(negedge clk);
      do_reset();
      check("mid_tx_en", tx_en, 0);
      check("mid_data_byte", data_byte, 8'h00);
      check("mid_empty", empty, 1);
      check("mid_count", fifo_count, 0);
      check("mid_overflow", overflow, 0);
      check("mid_timeout_err", timeout_err, 0);
      repeat (40) @(negedge clk);
      check("mid_no_stale_launch", n_launch - launch_base, 0);

      // Randomized traffic with a random busy line and random frame lengths
      rand_len = 1'b1;
      for (int c = 0; c < 400; c++) begin
         uart_state = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1 && (n_acc - (n_launch - launch_base)) < DEPTH)
            push(8'($urandom), 1'b1);
         else
            @(negedge clk);
      end
      drain("rand_drain", 3000);
      check("rand_launches", n_launch - launch_base, n_acc);
      check("rand_overflow", overflow, 0);
      check("rand_empty", empty, 1);

      // Watchdog abort with TIMEOUT=8, followed by launch of the next byte
      w_wr_en = 1'b1; w_wr_data = 8'h3C;
      @(negedge clk);
      w_wr_data = 8'h5A;
      @(negedge clk);
      w_wr_en = 1'b0;
      n = 0;
      while (!w_tx_en && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("wd_launch", w_tx_en, 1);
      check("wd_byte0", w_data_byte, 8'h3C);
      hi = 0;
      while (w_tx_en === 1'b1 && hi < 50) begin
         hi++;
         @(negedge clk);
      end
      check("wd_frame_cycles", hi, 8);
      check("wd_timeout_err", w_timeout_err, 1);
      @(negedge clk);
      check("wd_next_launch", w_tx_en, 1);
      check("wd_byte1", w_data_byte, 8'h5A);
      hi = 0;
      while (w_tx_en === 1'b1 && hi < 50) begin
         hi++;
         @(negedge clk);
      end
      check("wd_frame2_cycles", hi, 8);

      // tx_done on the final watchdog cycle wins over the abort
      w_reset = 1'b1;
      @(negedge clk);
      w_reset = 1'b0;
      check("wd_rst_timeout_err", w_timeout_err, 0);
      w_wr_en = 1'b1; w_wr_data = 8'h99;
      @(negedge clk);
      w_wr_en = 1'b0;
      n = 0;
      while (!w_tx_en && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("wd2_launch", w_tx_en, 1);
      repeat (7) @(negedge clk);
      check("wd2_still_high_cycle8", w_tx_en, 1);
      w_tx_done = 1'b1;
      @(negedge clk);
      w_tx_done = 1'b0;
      check("wd2_tx_en_low", w_tx_en, 0);
      check("wd2_timeout_err", w_timeout_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte buffer and launch controller that sits directly upstream of the UART transmitter.
- Accepts bytes from a host-side write port into a synchronous FIFO.
- Presents one byte at a time to the transmitter on data_byte and holds tx_en high for the whole frame.
- Releases tx_en on the transmitter's tx_done pulse, then launches the next queued byte. A watchdog recovers from a transmitter that never signals completion.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of 2.
- ADDR_W, 4, log2(DEPTH).
- TIMEOUT, 32'd2000000, maximum clk cycles in SEND without tx_done before abort; must be >= 2.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  host write strobe; one byte per cycle.
- wr_data  input  8  host byte to enqueue.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- fifo_count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; a write was attempted while full.
- timeout_err  output  1  sticky; a frame was aborted by the watchdog.
- tx_en  output  1  to transmitter; high for the duration of one frame.
- data_byte  output  8  to transmitter; byte being sent, stable while tx_en=1.
- tx_done  input  1  from transmitter; 1-cycle pulse at end of frame.
- uart_state  input  1  from transmitter; 1 = busy.

Behaviour:
- Clocking and reset:
  - All state updates on rising clk.
  - When reset=1 at an edge: pointers=0, fifo_count=0, empty=1, full=0, overflow=0, timeout_err=0, tx_en=0, data_byte=8'h00, watchdog=0, state=IDLE.
  - Reset mid-frame drops tx_en on the next cycle; the current byte and all queued bytes are discarded.
- FIFO:
  - Write accepted when wr_en=1 and (full=0 or a pop occurs in the same cycle).
  - A write attempted while full with no simultaneous pop is dropped and sets overflow=1. overflow clears only on reset.
  - Pointers are ADDR_W bits and wrap modulo DEPTH.
  - fifo_count is updated as follows: +1 on write only, -1 on pop only, unchanged when a write and a pop occur together.
  - full, empty and fifo_count are registered and reflect the count after the edge.
  - Write-to-visible latency is 1 cycle: a write at edge N gives empty=0 during cycle N+1.
- FSM states: IDLE, SEND.
- IDLE:
  - tx_en=0.
  - If empty=0 and uart_state=0 and tx_done=0, then at the edge:
    - pop the head: data_byte<=mem[rd_ptr], rd_ptr+1;
    - tx_en<=1, watchdog<=0, state<=SEND.
  - Otherwise hold. data_byte retains its last value.
- SEND:
  - tx_en=1; data_byte held constant; watchdog increments each cycle.
  - On tx_done=1: tx_en<=0, state<=IDLE.
  - On watchdog==TIMEOUT-1 with tx_done=0: tx_en<=0, timeout_err<=1, state<=IDLE. The byte is lost and not retried.
  - If tx_done and the timeout occur in the same cycle, tx_done wins and timeout_err is not set.
- Inter-frame spacing: tx_en stays low for at least 1 cycle between frames. The next launch additionally waits for uart_state=0.
- tx_done outside SEND is ignored.
- Latency:
  - Write into an empty FIFO while idle: tx_en rises 2 cycles after the write edge.
  - tx_done pulse at edge M: tx_en=0 during cycle M+1. If the FIFO is non-empty and uart_state=0, tx_en=1 again from M+2.
- Ordering: bytes are transmitted strictly in write order; no byte is duplicated.

Test Plan:
- Single byte: after reset, write 8'hA5 once, uart_state=0; model tx_done 100 cycles after tx_en rises -> tx_en high 2 cycles after the write, data_byte=8'hA5 stable throughout, tx_en low the cycle after tx_done, empty=1, fifo_count=0.
- Burst order: write 8'h01..8'h10 (16 bytes) on consecutive cycles -> full=1 after 16th write, fifo_count=16; transmitted sequence 01..10 in order, with exactly one cycle of tx_en=0 between frames.
- Overflow: fill 16 bytes with no transmitter progress (uart_state=1), write 8'hFF -> overflow=1, fifo_count stays 16, 8'hFF never transmitted. A write while full in the same cycle as a pop is accepted: fifo_count unchanged, overflow unchanged.
- Busy gating: hold uart_state=1 with the FIFO non-empty -> tx_en stays 0. Release uart_state -> tx_en=1 within 1 cycle.
- Watchdog: TIMEOUT=8, tx_done never asserted -> tx_en falls after 8 cycles in SEND, timeout_err=1, next byte launched. Separately, tx_done on the 8th cycle -> timeout_err stays 0.
- Reset mid-frame: 3 bytes queued, assert reset during SEND -> next cycle tx_en=0, data_byte=8'h00, empty=1, sticky flags cleared; no stale byte is sent after reset deasserts.
